// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Types and constants shared by the instruction-ROM arbiter files.
//   arb_state_e   : arbiter FSM states (idle / access in flight)
//   arb_owner_e   : which requester owns the in-flight ROM access
//   ROM_LAT_MAX   : largest supported ROM read latency
//   LAT_CNT_W     : width of the latency counter (holds 0..ROM_LAT_MAX)
//   STARVE_CNT_W  : width of the fairness starvation counter (holds 0..15)
// -----------------------------------------------------------------------------
package rom_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam int ROM_LAT_MAX  = 15;
    localparam int LAT_CNT_W    = $clog2(ROM_LAT_MAX + 1);
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/rom_arb_if.sv
// -----------------------------------------------------------------------------
// rom_arb_if
// Bundle of every handshake and bus signal around the ROM arbiter.
//   if_req/if_addr   -> arbiter : fetch read request and word address
//   if_gnt           <- arbiter : fetch request accepted this cycle
//   if_rvalid/rdata  <- arbiter : one-cycle pulse with the instruction word
//   ls_*             : the same set for the load/store requester
//   rom_addr         <- arbiter : registered ROM read address
//   rom_data         -> arbiter : ROM read data
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (both requesters plus the ROM macro)
// -----------------------------------------------------------------------------
interface rom_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  rom_addr
    );

endinterface

// File: rtl/rom_arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// rom_arb_starve_ctr
// Fairness counter for the ROM arbiter: counts consecutive LS grants made
// while fetch is waiting, and forces the next idle grant to fetch once the
// count reaches STARVE_MAX. Only instantiated when ROM_ARB_FAIRNESS_EN is
// defined.
// Ports:
//   clk       in  : clock
//   rst       in  : synchronous active-high reset
//   if_req    in  : fetch request level at the time of a grant
//   grant_if  in  : fetch granted this cycle
//   grant_ls  in  : load/store granted this cycle
//   force_if  out : next idle grant must go to fetch if it is requesting
// -----------------------------------------------------------------------------
module rom_arb_starve_ctr
    import rom_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic grant_if,
    input  logic grant_ls,
    output logic force_if
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    // The counter never passes STARVE_LIM: at the limit the next grant is
    // either to fetch or made with fetch idle, and both clear it.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_ls) begin
            starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
        end
    end

    assign force_if = (starve_cnt == STARVE_LIM);

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares the single instruction-ROM read port between fetch (IF) and
// load/store (LS). One access at a time: a combinational grant in IDLE,
// the address held on rom_addr for ROM_LAT cycles, then the ROM word is
// returned to the owner with a one-cycle rvalid pulse. LS has priority.
// Build option:
//   ROM_ARB_FAIRNESS_EN : when defined, after STARVE_MAX consecutive LS
//                         grants with IF waiting, the next grant goes to IF.
// Ports:
//   clk  in : clock, all state on posedge
//   rst  in : synchronous active-high reset (aborts any in-flight access)
//   bus     : rom_arb_if.slave - both requester handshakes and the ROM port
// -----------------------------------------------------------------------------
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     rst,
    rom_arb_if.slave bus
);

    localparam logic [0:0] S_IDLE = ARB_IDLE;
    localparam logic [0:0] S_BUSY = ARB_BUSY;

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(ROM_LAT - 1);

    logic [0:0]           state;
    logic [LAT_CNT_W-1:0] lat_cnt;
    arb_owner_e           owner;
    logic [ADDR_W-1:0]    rom_addr_q;
    logic                 if_rvalid_q;
    logic [DATA_W-1:0]    if_rdata_q;
    logic                 ls_rvalid_q;
    logic [DATA_W-1:0]    ls_rdata_q;

    logic grant_if;
    logic grant_ls;
    logic force_if;

`ifdef ROM_ARB_FAIRNESS_EN
    rom_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .grant_if (grant_if),
        .grant_ls (grant_ls),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Grants are gated by rst so both gnt outputs read 0 while in reset.
    // NOTE: every signal assigned in always_comb gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (bus.ls_req && !(force_if && bus.if_req)) begin
                grant_ls = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            owner       <= OWN_IF;
            rom_addr_q  <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            // rvalid is a pulse: cleared every cycle unless set below.
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (state == S_IDLE) begin
                if (grant_ls || grant_if) begin
                    rom_addr_q <= grant_ls ? bus.ls_addr : bus.if_addr;
                    owner      <= grant_ls ? OWN_LS : OWN_IF;
                    lat_cnt    <= LAT_LOAD;
                    state      <= S_BUSY;
                end
            end else begin
                if (lat_cnt == '0) begin
                    if (owner == OWN_LS) begin
                        ls_rdata_q  <= bus.rom_data;
                        ls_rvalid_q <= 1'b1;
                    end else begin
                        if_rdata_q  <= bus.rom_data;
                        if_rvalid_q <= 1'b1;
                    end
                    state <= S_IDLE;
                end else begin
                    lat_cnt <= lat_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.ls_gnt    = grant_ls;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.rom_addr  = rom_addr_q;

endmodule
